// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared Rijndael types, NB legality check and ShiftRows offsets.
// Revision    : 1.0
// ============================================================================
package aes_pkg;

    typedef logic [7:0] byte_t;

    localparam int NB_MAX = 8;

    function automatic bit nb_is_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == NB_MAX);
    endfunction

    // Wide blocks use 0,1,3,4; NB=4 and NB=6 use 0,1,2,3.
    function automatic int shift_offset(input int row, input int nb);
        if ((nb == 8) && (row >= 2))
            return row + 1;
        return row;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_rows_perm.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_perm
// Description : Combinational ShiftRows / InvShiftRows byte permutation.
// Revision    : 1.0
// ============================================================================
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] data_in,
    input  logic             inv,
    output logic [32*NB-1:0] data_out
);

    localparam int W = 32 * NB;

    genvar r, c;
    generate
        for (r = 0; r < 4; r++) begin : g_row
            for (c = 0; c < NB; c++) begin : g_col
                localparam int OFF   = shift_offset(r, NB);
                localparam int FWD_C = (c + OFF) % NB;
                localparam int INV_C = (c + NB - OFF) % NB;

                byte_t w_fwd;
                byte_t w_inv;

                assign w_fwd = data_in[W-1-8*(r+4*FWD_C) -: 8];
                assign w_inv = data_in[W-1-8*(r+4*INV_C) -: 8];
                assign data_out[W-1-8*(r+4*c) -: 8] = inv ? w_inv : w_fwd;
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/shift_rows_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_rows_stage
// Description : Registered ShiftRows/InvShiftRows stage with 2-entry elastic buffer.
// Revision    : 1.0
// ============================================================================
module shift_rows_stage
    import aes_pkg::*;
#(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [32*NB-1:0] in_data,
    input  logic             in_inv,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [32*NB-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam int W = 32 * NB;

    generate
        if (!nb_is_legal(NB)) begin : g_bad_nb
            $error("shift_rows_stage: NB must be 4, 6 or 8");
        end
        if (TAG_W < 1) begin : g_bad_tag
            $error("shift_rows_stage: TAG_W must be at least 1");
        end
    endgenerate

    logic [W-1:0]     w_perm;
    logic             w_push;
    logic             w_pop;
    logic             w_rd_nxt;
    logic [1:0]       w_count_nxt;
    logic             w_head_from_in;

    logic [W-1:0]     r_data [2];
    logic [TAG_W-1:0] r_tag  [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic [W-1:0]     r_out_data;
    logic [TAG_W-1:0] r_out_tag;

    shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .data_in  (in_data),
        .inv      (in_inv),
        .data_out (w_perm)
    );

    assign in_ready  = (r_count != 2'd2);
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

    assign w_push   = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;
    assign w_rd_nxt = r_rd_ptr ^ w_pop;
    // The next head is the incoming block when it lands in the slot being read next.
    assign w_head_from_in = w_push && (r_wr_ptr == w_rd_nxt);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 2'd1;
            2'b01:   w_count_nxt = r_count - 2'd1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Output registers mirror the head entry so nothing sits after the flops.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_out_data <= '0;
            r_out_tag  <= '0;
        end else begin
            if (w_push) begin
                r_data[r_wr_ptr] <= w_perm;
                r_tag[r_wr_ptr]  <= in_tag;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
            if (w_count_nxt != 2'd0) begin
                r_out_data <= w_head_from_in ? w_perm : r_data[w_rd_nxt];
                r_out_tag  <= w_head_from_in ? in_tag : r_tag[w_rd_nxt];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_rows_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_rows_stage
// Description : Directed and scoreboarded checks of shift_rows_stage (NB=4/6/8).
// Revision    : 1.0
// ============================================================================
module tb_shift_rows_stage;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    logic         v4_in_valid, v4_in_ready, v4_in_inv, v4_out_valid, v4_out_ready;
    logic [127:0] v4_in_data, v4_out_data;
    logic [3:0]   v4_in_tag, v4_out_tag;

    logic         v8_in_valid, v8_in_ready, v8_in_inv, v8_out_valid, v8_out_ready;
    logic [255:0] v8_in_data, v8_out_data;
    logic [3:0]   v8_in_tag, v8_out_tag;

    logic         v6_in_valid, v6_in_ready, v6_in_inv, v6_out_valid, v6_out_ready;
    logic [191:0] v6_in_data, v6_out_data;
    logic [3:0]   v6_in_tag, v6_out_tag;

    shift_rows_stage #(.NB(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .n_rst(n_rst),
        .in_valid(v4_in_valid), .in_ready(v4_in_ready), .in_data(v4_in_data),
        .in_inv(v4_in_inv), .in_tag(v4_in_tag),
        .out_valid(v4_out_valid), .out_ready(v4_out_ready),
        .out_data(v4_out_data), .out_tag(v4_out_tag)
    );

    shift_rows_stage #(.NB(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .n_rst(n_rst),
        .in_valid(v8_in_valid), .in_ready(v8_in_ready), .in_data(v8_in_data),
        .in_inv(v8_in_inv), .in_tag(v8_in_tag),
        .out_valid(v8_out_valid), .out_ready(v8_out_ready),
        .out_data(v8_out_data), .out_tag(v8_out_tag)
    );

    shift_rows_stage #(.NB(6), .TAG_W(4)) u_dut6 (
        .clk(clk), .n_rst(n_rst),
        .in_valid(v6_in_valid), .in_ready(v6_in_ready), .in_data(v6_in_data),
        .in_inv(v6_in_inv), .in_tag(v6_in_tag),
        .out_valid(v6_out_valid), .out_ready(v6_out_ready),
        .out_data(v6_out_data), .out_tag(v6_out_tag)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [131:0] sbq [$];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] model(input logic [255:0] d, input bit inv, input int nb);
        logic [255:0] o;
        int off, src;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                off = ((nb == 8) && (r >= 2)) ? r + 1 : r;
                src = inv ? (c - off + nb) % nb : (c + off) % nb;
                o[32*nb-1-8*(r+4*c) -: 8] = d[32*nb-1-8*(r+4*src) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a falling edge: drives one cycle of NB=4 stimulus, checks the
    // handshake the coming rising edge will see, and returns at the next falling edge.
    task automatic step(input bit v, input bit inv, input logic [127:0] d, input logic [3:0] t,
                        input bit rdy, output bit pushed, output bit popped);
        logic [131:0] e;
        logic [255:0] m;
        v4_in_valid  = v;
        v4_in_inv    = inv;
        v4_in_data   = d;
        v4_in_tag    = t;
        v4_out_ready = rdy;
        #1;
        chk("in_ready", v4_in_ready, sbq.size() != 2);
        chk("out_valid", v4_out_valid, sbq.size() != 0);
        popped = v4_out_valid && rdy;
        pushed = v && v4_in_ready;
        if (popped) begin
            if (sbq.size() == 0) begin
                chk("pop_empty", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("pop_data", v4_out_data, e[127:0]);
                chk("pop_tag", v4_out_tag, e[131:128]);
            end
        end
        if (pushed) begin
            m = model({128'd0, d}, inv, 4);
            sbq.push_back({t, m[127:0]});
        end
        @(negedge clk);
    endtask

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit pu, po;
        logic [127:0] d, f, first;
        logic [255:0] pat8, m;
        logic [191:0] pat6;
        int tagn, npop, idle;

        n_rst = 1'b0;
        {v4_in_valid, v4_in_inv, v4_out_ready, v4_in_data, v4_in_tag} = '0;
        {v8_in_valid, v8_in_inv, v8_out_ready, v8_in_data, v8_in_tag} = '0;
        {v6_in_valid, v6_in_inv, v6_out_ready, v6_in_data, v6_in_tag} = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", v4_out_valid, 0);
        chk("rst_in_ready", v4_in_ready, 1);
        chk("rst_out_data", v4_out_data, 0);
        chk("rst_out_tag", v4_out_tag, 0);
        n_rst = 1'b1;
        @(negedge clk);

        // FIPS-197 round-1 ShiftRows, then its inverse
        step(1, 0, FIPS_IN, 4'd3, 0, pu, po);
        v4_in_valid = 1'b0;
        chk("fwd_valid", v4_out_valid, 1);
        chk("fwd_data", v4_out_data, FIPS_OUT);
        chk("fwd_tag", v4_out_tag, 4'd3);
        step(0, 0, '0, 0, 1, pu, po);
        step(1, 1, FIPS_OUT, 4'd9, 0, pu, po);
        v4_in_valid = 1'b0;
        chk("inv_data", v4_out_data, FIPS_IN);
        chk("inv_tag", v4_out_tag, 4'd9);
        step(0, 0, '0, 0, 1, pu, po);

        for (int i = 0; i < 4; i++) begin
            d = rnd128();
            step(1, 0, d, 4'(i), 0, pu, po);
            f = v4_out_data;
            step(0, 0, '0, 0, 1, pu, po);
            step(1, 1, f, 4'(i), 0, pu, po);
            v4_in_valid = 1'b0;
            chk("roundtrip", v4_out_data, d);
            step(0, 0, '0, 0, 1, pu, po);
        end

        // NB=8 and NB=6 byte-index patterns
        for (int n = 0; n < 32; n++) pat8[255-8*n -: 8] = 8'(n);
        for (int n = 0; n < 24; n++) pat6[191-8*n -: 8] = 8'(n);
        v8_in_data = pat8; v8_in_valid = 1'b1;
        v6_in_data = pat6; v6_in_valid = 1'b1;
        @(negedge clk);
        v8_in_valid = 1'b0; v6_in_valid = 1'b0;
        chk("nb8_valid", v8_out_valid, 1);
        chk("nb8_col0", v8_out_data[255:224], 32'h00050e13);
        chk("nb8_col7", v8_out_data[31:0], 32'h1c010a0f);
        chk("nb8_full", v8_out_data, model(pat8, 0, 8));
        m = model({64'd0, pat6}, 0, 6);
        chk("nb6_full", v6_out_data, m[191:0]);
        v8_in_inv = 1'b1; v8_in_data = v8_out_data; v8_in_valid = 1'b1; v8_out_ready = 1'b1;
        @(negedge clk);
        v8_in_valid = 1'b0;
        chk("nb8_inv", v8_out_data, pat8);
        v6_out_ready = 1'b1;
        @(negedge clk);
        chk("nb8_drained", v8_out_valid, 0);
        chk("nb6_drained", v6_out_valid, 0);

        // Backpressure: offer tags 0..7 with out_ready low
        tagn = 0;
        for (int c = 0; c < 6; c++) begin
            step(1, 0, rnd128(), 4'(tagn), 0, pu, po);
            if (pu) tagn++;
            if (c == 0) first = v4_out_data;
            else chk("bp_hold", v4_out_data, first);
        end
        chk("bp_accepts", tagn, 2);
        chk("bp_in_ready", v4_in_ready, 0);
        npop = 0; idle = 0;
        for (int c = 0; c < 30 && npop < 8; c++) begin
            if (!v4_out_valid) idle++;
            step(tagn < 8, 0, rnd128(), 4'(tagn), 1, pu, po);
            if (pu) tagn++;
            if (po) npop++;
        end
        chk("bp_popped", npop, 8);
        chk("bp_pushed", tagn, 8);
        chk("bp_idle", idle, 0);

        // Random valid/ready with mixed modes
        for (int c = 0; c < 1000; c++)
            step($urandom_range(0, 1), $urandom_range(0, 1), rnd128(), 4'($urandom),
                 $urandom_range(0, 1), pu, po);
        for (int c = 0; c < 4; c++) step(0, 0, '0, 0, 1, pu, po);
        chk("rand_drained", v4_out_valid, 0);

        // Asynchronous reset with the buffer full
        step(1, 0, rnd128(), 4'd1, 0, pu, po);
        step(1, 0, rnd128(), 4'd2, 0, pu, po);
        #2 n_rst = 1'b0;
        #1;
        chk("mrst_out_valid", v4_out_valid, 0);
        chk("mrst_in_ready", v4_in_ready, 1);
        chk("mrst_out_data", v4_out_data, 0);
        chk("mrst_out_tag", v4_out_tag, 0);
        sbq.delete();
        v4_in_valid = 1'b1; v4_out_ready = 1'b1;
        @(negedge clk);
        chk("mrst_ignored", v4_out_valid, 0);
        n_rst = 1'b1;
        d = rnd128();
        step(1, 1, d, 4'd5, 0, pu, po);
        v4_in_valid = 1'b0;
        m = model({128'd0, d}, 1, 4);
        chk("post_rst_valid", v4_out_valid, 1);
        chk("post_rst_data", v4_out_data, m[127:0]);
        chk("post_rst_tag", v4_out_tag, 4'd5);
        step(0, 0, '0, 0, 1, pu, po);
        step(0, 0, '0, 0, 1, pu, po);
        chk("no_stale", v4_out_valid, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
